// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Holds the FSM state encoding and the framing constants for the byte stream.
package loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_LOAD,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    localparam int HDR_BYTES = 4;
    localparam int BCNT_W    = 2;

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte-to-word shift register with a one-cycle word-complete flag.
// The first byte of a word ends up in bits [7:0] once the last byte is shifted in.
module byte_packer
    import loader_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             nreset,
    input  logic             clear,
    input  logic             shift,
    input  logic [7:0]       byte_data,
    output logic [WIDTH-1:0] word,
    output logic             word_done
);

    localparam logic [BCNT_W-1:0] LAST = BCNT_W'(HDR_BYTES - 1);

    logic [BCNT_W-1:0] count;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            count     <= '0;
            word      <= '0;
            word_done <= 1'b0;
        end else if (clear) begin
            count     <= '0;
            word      <= '0;
            word_done <= 1'b0;
        end else begin
            word_done <= shift && (count == LAST);
            if (shift) begin
                // New bytes enter at the top so earlier bytes drift toward bit 0.
                word  <= {byte_data, word[WIDTH-1:8]};
                count <= (count == LAST) ? '0 : count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a framed byte stream (count, words, checksum) into instruction memory
// and holds the CPU until a load completes with a matching checksum.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// HEADER | collecting the 4-byte word count
// LOAD   | collecting program words and writing them to memory
// CHECK  | collecting the 4-byte checksum
// DONE   | load verified, CPU released
// ERROR  | bad count or checksum mismatch, CPU held
module imem_loader
    import loader_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2048
) (
    input  logic             clock,
    input  logic             nreset,
    input  logic             start,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_address,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             cpu_hold,
    output logic             busy,
    output logic             done,
    output logic             error
);

    state_t           state, state_nx;
    logic [WIDTH-1:0] n_words;
    logic [WIDTH-1:0] index;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] word;
    logic             word_done;
    logic             accept;
    logic             wr;

    assign busy       = (state == S_HEADER) || (state == S_LOAD) || (state == S_CHECK);
    assign byte_ready = busy && !start;
    assign accept     = byte_valid && byte_ready;
    assign done       = (state == S_DONE);
    assign error      = (state == S_ERROR);
    assign cpu_hold   = (state != S_DONE);

    // A completed word is written only while loading and never when a restart wins.
    assign wr          = word_done && (state == S_LOAD) && !start;
    assign mem_we      = wr;
    assign mem_address = wr ? (index << 2) : '0;
    assign mem_wdata   = wr ? word : '0;

    byte_packer #(
        .WIDTH(WIDTH)
    ) u_packer (
        .clock     (clock),
        .nreset    (nreset),
        .clear     (start),
        .shift     (accept),
        .byte_data (byte_data),
        .word      (word),
        .word_done (word_done)
    );

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (start) begin
            state_nx = S_HEADER;
        end else begin
            case (state)
                S_HEADER: begin
                    if (word_done) begin
                        if ((word == '0) || (word > WIDTH'(DEPTH)))
                            state_nx = S_ERROR;
                        else
                            state_nx = S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (word_done && (index == n_words - 1'b1))
                        state_nx = S_CHECK;
                end
                S_CHECK: begin
                    if (word_done)
                        state_nx = (word == sum) ? S_DONE : S_ERROR;
                end
                default: state_nx = state;
            endcase
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            n_words <= '0;
            index   <= '0;
            sum     <= '0;
        end else if (start) begin
            n_words <= '0;
            index   <= '0;
            sum     <= '0;
        end else begin
            if (word_done && (state == S_HEADER))
                n_words <= word;
            if (wr) begin
                index <= index + 1'b1;
                sum   <= sum + word;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized bench for imem_loader; streams are built from a
// word list and the expected writes/status are derived from the framing rules.
module tb_imem_loader;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2048;

    logic             clock = 1'b0;
    logic             nreset = 1'b0;
    logic             start = 1'b0;
    logic             byte_valid = 1'b0;
    logic [7:0]       byte_data = 8'h00;
    logic             byte_ready;
    logic             mem_we;
    logic [WIDTH-1:0] mem_address;
    logic [WIDTH-1:0] mem_wdata;
    logic             cpu_hold;
    logic             busy;
    logic             done;
    logic             error;

    int checks = 0;
    int errors = 0;

    logic [7:0]       stream[$];
    logic [WIDTH-1:0] exp_words[$];
    logic [WIDTH-1:0] got_addr[$];
    logic [WIDTH-1:0] got_data[$];

    imem_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock       (clock),
        .nreset      (nreset),
        .start       (start),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_ready  (byte_ready),
        .mem_we      (mem_we),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .cpu_hold    (cpu_hold),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (mem_we) begin
            got_addr.push_back(mem_address);
            got_data.push_back(mem_wdata);
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cpu_hold"}, cpu_hold, 1);
        chk({tag, "_byte_ready"}, byte_ready, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_address"}, mem_address, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) stream.push_back(w[8*i +: 8]);
    endtask

    // Header count, exp_words, then checksum (sum mod 2^32, optionally corrupted).
    task automatic build_stream(input logic [31:0] n, input bit bad);
        logic [31:0] s;
        logic [31:0] flip;
        s = 0;
        stream.delete();
        push_word(n);
        foreach (exp_words[i]) begin
            push_word(exp_words[i]);
            s = s + exp_words[i];
        end
        flip = 32'h1 << $urandom_range(0, 31);
        push_word(bad ? (s ^ flip) : s);
    endtask

    // mode 0: back-to-back, 1: one idle cycle between bytes, 2: random gaps
    task automatic send_stream(input int mode, input int limit);
        int gaps;
        int waited;
        for (int i = 0; i < stream.size() && i < limit; i++) begin
            gaps = (mode == 0) ? 0 : (mode == 1) ? 1 : $urandom_range(0, 3);
            for (int g = 0; g < gaps; g++) begin
                byte_valid = 1'b0;
                byte_data  = 8'($urandom);
                @(negedge clock);
            end
            byte_valid = 1'b1;
            byte_data  = stream[i];
            #1;
            waited = 0;
            while (!byte_ready && waited < 20) begin
                @(negedge clock);
                #1;
                waited++;
            end
            if (waited >= 20) begin
                chk("byte_accept_timeout", byte_ready, 1);
                break;
            end
            @(posedge clock);
            @(negedge clock);
            byte_valid = 1'b0;
        end
    endtask

    task automatic do_start(input bit with_byte);
        @(negedge clock);
        start      = 1'b1;
        byte_valid = with_byte;
        byte_data  = 8'hAA;
        #1;
        chk("ready_during_start", byte_ready, 0);
        @(negedge clock);
        start      = 1'b0;
        byte_valid = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("done_after_start", done, 0);
        chk("error_after_start", error, 0);
    endtask

    task automatic wait_end(input bit exp_done);
        int n;
        n = 0;
        while (!(done || error) && n < 12) begin
            @(negedge clock);
            n++;
        end
        chk("end_done", done, exp_done);
        chk("end_error", error, !exp_done);
        chk("end_cpu_hold", cpu_hold, !exp_done);
        chk("end_busy", busy, 0);
        chk("end_byte_ready", byte_ready, 0);
    endtask

    task automatic check_writes();
        chk("write_count", got_addr.size(), exp_words.size());
        for (int i = 0; i < got_addr.size() && i < exp_words.size(); i++) begin
            chk("write_addr", got_addr[i], i * 4);
            chk("write_data", got_data[i], exp_words[i]);
        end
        got_addr.delete();
        got_data.delete();
    endtask

    task automatic run_case(input int mode, input bit bad, input bit start_byte);
        do_start(start_byte);
        build_stream(exp_words.size(), bad);
        send_stream(mode, stream.size());
        wait_end(!bad);
        check_writes();
    endtask

    task automatic header_error(input logic [31:0] n);
        do_start(0);
        exp_words.delete();
        stream.delete();
        push_word(n);
        send_stream(0, 4);
        wait_end(0);
        check_writes();
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        nreset = 1'b1;
        repeat (2) @(negedge clock);
        byte_valid = 1'b1;
        #1;
        chk("idle_ready", byte_ready, 0);
        byte_valid = 1'b0;

        exp_words = '{32'h00000013, 32'h00100093};
        run_case(0, 0, 0);

        exp_words = '{32'h00000013, 32'h00100093};
        run_case(2, 1, 0);

        header_error(32'd0);
        header_error(32'd2049);

        exp_words = '{32'hDEADBEEF};
        run_case(1, 0, 1);

        exp_words = '{32'h11111111, 32'h22222222, 32'h33333333};
        do_start(0);
        build_stream(3, 0);
        send_stream(0, 14);
        #2;
        nreset = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        void'(exp_words.pop_back());
        check_writes();
        @(negedge clock);
        nreset     = 1'b1;
        byte_valid = 1'b1;
        repeat (6) @(negedge clock);
        chk("post_reset_ready", byte_ready, 0);
        chk("post_reset_writes", got_addr.size(), 0);
        byte_valid = 1'b0;
        exp_words = '{32'hCAFEF00D};
        run_case(2, 0, 0);

        exp_words = '{32'h12345678};
        run_case(0, 0, 0);

        for (int r = 0; r < 6; r++) begin
            exp_words.delete();
            for (int k = 0; k < $urandom_range(1, 8); k++) exp_words.push_back($urandom);
            run_case(2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        exp_words.delete();
        for (int k = 0; k < DEPTH; k++) exp_words.push_back($urandom);
        run_case(0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter WIDTH, default 32: memory word width and address width in bits.
REQ-002 Parameter DEPTH, default 2048: instruction-memory capacity in words.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 nreset  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  one-cycle pulse; begins or restarts a load.
REQ-006 byte_valid  input  1  upstream byte present.
REQ-007 byte_data  input  8  upstream byte.
REQ-008 byte_ready  output  1  loader accepts byte this cycle.
REQ-009 mem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 mem_address  output  WIDTH  byte address of write, word-aligned (bits [1:0] = 0).
REQ-011 mem_wdata  output  WIDTH  word to write.
REQ-012 cpu_hold  output  1  high keeps CPU out of execution.
REQ-013 busy, done, error  output  1 each  status flags.

Function
REQ-014 Stream format SHALL be: 4-byte word count N, then N program words, then a 4-byte checksum; all values little-endian (first byte = bits [7:0]).
REQ-015 A byte SHALL be consumed only on a cycle with byte_valid && byte_ready.
REQ-016 byte_ready SHALL equal (state is HEADER, LOAD or CHECK) && !start.
REQ-017 States SHALL be IDLE, HEADER, LOAD, CHECK, DONE, ERROR.
REQ-018 start in any state SHALL go to HEADER, clearing byte counter, word index, running sum, done and error; start has priority over every other event.
REQ-019 HEADER: after 4th byte, N==0 or N>DEPTH -> ERROR; otherwise latch N -> LOAD.
REQ-020 LOAD: on 4th byte of a word, the following cycle SHALL drive mem_we=1 with mem_address=index*4 and the assembled word; index increments and sum += word (mod 2^WIDTH) in that same cycle.
REQ-021 Byte acceptance SHALL continue without a bubble while mem_we is high (one word per 4 accepted bytes max).
REQ-022 After word N-1 is written -> CHECK; after 4 checksum bytes, received == sum -> DONE, else -> ERROR.
REQ-023 mem_we SHALL never assert outside LOAD-caused writes and never for index >= N.
REQ-024 busy=1 in HEADER/LOAD/CHECK; done=1 only in DONE; error=1 only in ERROR.
REQ-025 cpu_hold SHALL be 0 only in DONE.
REQ-026 DONE and ERROR SHALL persist until start or reset; bytes arriving in IDLE/DONE/ERROR are not accepted (byte_ready=0).
REQ-027 byte_valid gaps of any length SHALL not alter partial-word state.

Reset
REQ-028 nreset low SHALL asynchronously force IDLE, cpu_hold=1, byte_ready=0, mem_we=0, mem_address=0, mem_wdata=0, busy/done/error=0, counters and sum=0.
REQ-029 Reset mid-load SHALL abandon the load; no write issues after reset release until a new start.

Structure
REQ-030 Package loader_pkg SHALL hold the state enum, the 4-byte header/checksum length constant, and the byte-counter width.
REQ-031 Sub-module byte_packer SHALL shift 8-bit bytes into a WIDTH-bit little-endian word and flag word-complete; FSM, index, sum and memory outputs stay in imem_loader.

Verification
REQ-032 Reset, then start, N=2, words 0x00000013, 0x00100093, checksum 0x001000A6 -> writes to addresses 0x0 and 0x4 with those data, then done=1, cpu_hold=0.
REQ-033 Same stream with checksum 0x001000A7 -> both writes occur, then error=1, cpu_hold=1, done=0.
REQ-034 Header N=0, and separately N=2049 -> ERROR after 4th header byte, no mem_we.
REQ-035 N=1 word 0xDEADBEEF with byte_valid toggling every other cycle and start asserted with a valid byte -> byte ignored that cycle; write data 0xDEADBEEF at address 0x0.
REQ-036 nreset low after 2 of 3 words -> all outputs at reset values immediately; no further writes; fresh start with N=1 reloads address 0x0.
REQ-037 start pulse in DONE, then stream N=1, word 0x12345678 -> done clears on start, single write at 0x0, done re-asserts.
